// File: rtl/dsp_arbiter_pkg.sv
// dsp_arbiter_pkg: shared DSP bus widths, arbiter FSM state codes and a one-hot index helper
package dsp_arbiter_pkg;
  localparam int DSP_INS_W = 44;
  localparam int DSP_OUTS_W = 84;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP = 2'd2;
  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    onehot_idx = '0;
    for (int i = 0; i < 8; i++)
      if (v[i]) onehot_idx = 3'(i);
  endfunction
endpackage

// File: rtl/dsp_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder; req/ptr in, one-hot win out (search starts at ptr+1, wraps)
module rr_pick #(
  parameter int N = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win
);
  logic [PW-1:0] idx;
  // Walk from the farthest candidate to the nearest so the nearest requester overwrites the rest.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      idx = PW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        win = '0;
        win[idx] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dsp_arbiter.sv
// dsp_arbiter: round-robin time-sharing of one DSP48A1 among ALU clients, zero-opmode flush gap between grants; DSP_ARB_TIMEOUT_EN adds a hold watchdog
// ports: clk, reset (async high), req/gnt per client, cl_dsp_ins_flat -> dsp_ins_flat mux, dsp_outs_flat -> cl_dsp_outs_flat broadcast, timeout_err (watchdog build only)
module dsp_arbiter
  import dsp_arbiter_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int GAP_CYCLES = 2,
  parameter int MAX_HOLD = 64
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CLIENTS-1:0]           req,
  output logic [NUM_CLIENTS-1:0]           gnt,
  input  logic [NUM_CLIENTS*DSP_INS_W-1:0] cl_dsp_ins_flat,
  output logic [DSP_INS_W-1:0]             dsp_ins_flat,
  input  logic [DSP_OUTS_W-1:0]            dsp_outs_flat,
  output logic [DSP_OUTS_W-1:0]            cl_dsp_outs_flat
`ifdef DSP_ARB_TIMEOUT_EN
  ,
  output logic                             timeout_err
`endif
);
  localparam int PW = $clog2(NUM_CLIENTS);
  localparam logic [1:0] GAP_INIT = 2'(GAP_CYCLES - 1);
  if (NUM_CLIENTS < 2 || NUM_CLIENTS > 8 || GAP_CYCLES < 1 || GAP_CYCLES > 3 || MAX_HOLD < 2) begin : g_bad_params
    $error("dsp_arbiter: parameter out of range");
  end
  logic [1:0] state_q, state_d;
  logic [NUM_CLIENTS-1:0] gnt_q, gnt_d, elig, win;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [1:0] gap_q, gap_d;
  logic own_req, drop;
  assign own_req = |(req & gnt_q);
`ifdef DSP_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold_q, hold_d;
  logic [NUM_CLIENTS-1:0] mask_q, mask_d;
  logic tmo_q, hit;
  // A timed-out client stays masked until it lowers req, so a stuck request cannot re-grab the slice.
  assign hit = state_q == ST_GRANT && own_req && hold_q == HW'(MAX_HOLD - 1);
  assign drop = !own_req || hit;
  assign elig = req & ~mask_q;
  assign timeout_err = tmo_q;
  always_comb begin
    hold_d = (state_q == ST_GRANT && !drop) ? hold_q + 1'b1 : '0;
    mask_d = (mask_q | (hit ? gnt_q : '0)) & req;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hold_q <= '0;
      mask_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      mask_q <= mask_d;
      tmo_q <= hit;
    end
`else
  assign drop = !own_req;
  assign elig = req;
`endif
  rr_pick #(.N(NUM_CLIENTS), .PW(PW)) u_pick (.req(elig), .ptr(ptr_q), .win(win));
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    gap_d = gap_q;
    if (state_q == ST_IDLE) begin
      if (|elig) begin
        gnt_d = win;
        ptr_d = PW'(onehot_idx(8'(win)));
        state_d = ST_GRANT;
      end
    end else if (state_q == ST_GRANT) begin
      if (drop) begin
        gnt_d = '0;
        gap_d = GAP_INIT;
        state_d = ST_GAP;
      end
    end else begin
      gap_d = gap_q - 2'd1;
      state_d = gap_q == 2'd0 ? ST_IDLE : ST_GAP;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q <= '0;
      ptr_q <= PW'(NUM_CLIENTS - 1);
      gap_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
      gap_q <= gap_d;
    end
  // With gnt clear (gap, idle, reset) the slice sees opmode 0, so X=Z=ZERO and P flushes.
  always_comb begin
    dsp_ins_flat = '0;
    for (int i = 0; i < NUM_CLIENTS; i++)
      dsp_ins_flat |= gnt_q[i] ? cl_dsp_ins_flat[DSP_INS_W*i +: DSP_INS_W] : '0;
  end
  assign gnt = gnt_q;
  assign cl_dsp_outs_flat = dsp_outs_flat;
endmodule

// File: tb/tb_dsp_arbiter.sv
// tb_dsp_arbiter: vector table, directed corner sequences and randomized traffic against a round-robin reference model
module tb_dsp_arbiter;
  import dsp_arbiter_pkg::*;
  localparam int N = 4;
  localparam int GAP = 2;
  localparam int MH = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] gnt;
  logic [N*DSP_INS_W-1:0] cl_ins;
  logic [DSP_INS_W-1:0] ins;
  logic [DSP_OUTS_W-1:0] outs, cl_outs;
`ifdef DSP_ARB_TIMEOUT_EN
  logic tmo;
`endif
  always #5 clk = ~clk;
  dsp_arbiter #(.NUM_CLIENTS(N), .GAP_CYCLES(GAP), .MAX_HOLD(MH)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .gnt(gnt),
    .cl_dsp_ins_flat(cl_ins),
    .dsp_ins_flat(ins),
    .dsp_outs_flat(outs),
    .cl_dsp_outs_flat(cl_outs)
`ifdef DSP_ARB_TIMEOUT_EN
    ,
    .timeout_err(tmo)
`endif
  );
  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] gnt;
  } vec_t;
  vec_t tbl[21];
  logic [DSP_INS_W-1:0] words[N];
  int n_tests = 0;
  int n_fail = 0;
  int m_owner, m_last, m_block;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int idx_of(input logic [N-1:0] g);
    for (int i = 0; i < N; i++)
      if (g[i]) return i;
    return -1;
  endfunction
  function automatic logic [DSP_INS_W-1:0] word_of(input logic [N-1:0] g);
    logic [DSP_INS_W-1:0] w = '0;
    for (int i = 0; i < N; i++)
      if (g[i]) w = words[i];
    return w;
  endfunction
  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] g = '0;
    if (m_owner >= 0) g[m_owner] = 1'b1;
    return g;
  endfunction
  // Reference: an owner keeps the slice until its req is seen low; then GAP edges pass with
  // no grant, and the next edge picks the first requester after the last winner.
  task automatic model_step(input logic [N-1:0] r);
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1;
        m_block = GAP;
      end
    end else if (m_block > 0) m_block--;
    else
      for (int k = 1; k <= N; k++)
        if (m_owner < 0 && r[(m_last + k) % N]) begin
          m_owner = (m_last + k) % N;
          m_last = m_owner;
        end
  endtask
  task automatic do_reset;
    req = '0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_owner = -1;
    m_last = N - 1;
    m_block = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int order[$];
    int gaps[$];
    int zrun, hold, bad, held, prev_owner, c2, pulses, g3;
    logic [N-1:0] prev, r;
    words[0] = {8'h09, 18'h10000, 18'h08000};
    for (int i = 1; i < N; i++) words[i] = DSP_INS_W'({$urandom(), $urandom()});
    for (int i = 0; i < N; i++) cl_ins[DSP_INS_W*i +: DSP_INS_W] = words[i];
    outs = DSP_OUTS_W'({$urandom(), $urandom(), $urandom()});
    tbl = '{
      '{4'b0001, 4'b0001}, '{4'b0001, 4'b0001}, '{4'b0000, 4'b0000}, '{4'b0110, 4'b0000},
      '{4'b0110, 4'b0000}, '{4'b0110, 4'b0010}, '{4'b0110, 4'b0010}, '{4'b0100, 4'b0000},
      '{4'b0100, 4'b0000}, '{4'b0100, 4'b0000}, '{4'b0100, 4'b0100}, '{4'b1101, 4'b0100},
      '{4'b1001, 4'b0000}, '{4'b1001, 4'b0000}, '{4'b1001, 4'b0000}, '{4'b1001, 4'b1000},
      '{4'b0001, 4'b0000}, '{4'b0001, 4'b0000}, '{4'b0001, 4'b0000}, '{4'b0001, 4'b0001},
      '{4'b0000, 4'b0000}};
    do_reset();
    check("reset gnt", gnt, '0);
    check("reset ins", ins, '0);
`ifdef DSP_ARB_TIMEOUT_EN
    check("reset tmo", tmo, 1'b0);
`endif
    check("outs bcast a", cl_outs, outs);
    outs = DSP_OUTS_W'({$urandom(), $urandom(), $urandom()});
    #1 check("outs bcast b", cl_outs, outs);
    for (int e = 0; e < 21; e++) begin
      req = tbl[e].req;
      tick();
      check($sformatf("vec%0d gnt", e), gnt, tbl[e].gnt);
      check($sformatf("vec%0d ins", e), ins, word_of(tbl[e].gnt));
    end
    // Contention: everyone requests, each owner releases after 6 cycles and re-requests.
    do_reset();
    req = '1;
    zrun = 0;
    hold = 0;
    bad = 0;
    prev = '0;
    for (int c = 0; c < 300 && order.size() < 5; c++) begin
      tick();
      if (!$onehot0(gnt) || (gnt == '0 && ins != '0)) bad++;
      if (gnt != '0) begin
        if (prev == '0) begin
          order.push_back(idx_of(gnt));
          if (order.size() > 1) gaps.push_back(zrun);
          zrun = 0;
          hold = 0;
        end
        hold++;
        if (hold == 6) req = req & ~gnt;
      end else begin
        zrun++;
        req = '1;
      end
      prev = gnt;
    end
    check("rr grants", order.size(), 5);
    check("rr bad cycles", bad, 0);
    for (int k = 0; k < order.size(); k++) check($sformatf("rr order%0d", k), order[k], k % N);
    for (int k = 0; k < gaps.size(); k++) check($sformatf("rr gap%0d", k), gaps[k], GAP + 1);
    // Asynchronous reset in the third cycle of a grant.
    do_reset();
    req = 4'b0001;
    tick();
    check("pre-rst gnt", gnt, 4'b0001);
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    check("async rst gnt", gnt, '0);
    check("async rst ins", ins, '0);
`ifdef DSP_ARB_TIMEOUT_EN
    check("async rst tmo", tmo, 1'b0);
`endif
    @(negedge clk);
    reset = 1'b0;
    req = 4'b0110;
    tick();
    check("post-rst gnt", gnt, 4'b0010);
`ifdef DSP_ARB_TIMEOUT_EN
    do_reset();
    req = 4'b0100;
    tick();
    check("to first gnt", gnt, 4'b0100);
    req = 4'b1100;
    c2 = 1;
    pulses = 0;
    g3 = 0;
    for (int c = 0; c < 19; c++) begin
      tick();
      if (gnt[2]) c2++;
      if (tmo) pulses++;
      if (gnt[3]) begin
        g3++;
        if (g3 == 3) req[3] = 1'b0;
      end
    end
    check("to hold cycles", c2, MH);
    check("to pulses", pulses, 1);
    check("to client3 cycles", g3, 3);
    req[2] = 1'b0;
    tick();
    req[2] = 1'b1;
    tick();
    check("to regrant", gnt, 4'b0100);
`endif
    // Randomized traffic: requests stay up until granted; owners hold at most 6 cycles.
    do_reset();
    held = 0;
    prev_owner = -1;
    r = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if (i == m_owner) begin
          if (held >= 6 || $urandom_range(3) == 0) r[i] = 1'b0;
        end else if (!r[i]) r[i] = $urandom_range(7) == 0;
      req = r;
      model_step(r);
      tick();
      check($sformatf("rnd%0d gnt", c), gnt, m_gnt());
      check($sformatf("rnd%0d ins", c), ins, word_of(m_gnt()));
      held = (m_owner >= 0 && m_owner == prev_owner) ? held + 1 : (m_owner >= 0 ? 1 : 0);
      prev_owner = m_owner;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
